// File: rtl/ro_edge_counter.sv
// Ring-oscillator edge counter: synchronises osc_in and counts its rising edges over a
// programmable window of CLK cycles. Define RO_EDGE_CNT_SAT_EN to saturate the count (default wraps).
`timescale 1ns/1ps

module ro_edge_counter #(
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned WIN_W   = 12
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic               osc_in,
  input  logic               start,
  input  logic [WIN_W-1:0]   win_len,
  output logic               busy,
  output logic               valid,
  input  logic               ready,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StHold} state_e;

  state_e               state_q, state_d;
  logic                 s1_q, s2_q, s3_q;
  logic                 arm_q, arm_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [WIN_W-1:0]     rem_q, rem_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 edge_evt;
`ifndef RO_EDGE_CNT_SAT_EN
  logic [COUNT_W:0]     count_inc;
`endif

  assign edge_evt = s2_q & ~s3_q;

  always_comb begin
    state_d    = state_q;
    arm_d      = arm_q;
    win_d      = win_q;
    rem_d      = rem_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
`ifndef RO_EDGE_CNT_SAT_EN
    count_inc  = {1'b0, count_q} + {{COUNT_W{1'b0}}, 1'b1};
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StArm;
          arm_d      = 1'b0;
          win_d      = win_len;
          count_d    = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StArm: begin
        // Two cycles let stale edges drain out of the synchroniser before counting.
        if (!arm_q) begin
          arm_d = 1'b1;
        end else if (win_q == '0) begin
          state_d = StHold;
          valid_d = 1'b1;
        end else begin
          state_d = StMeasure;
          rem_d   = win_q;
        end
      end
      StMeasure: begin
        if (edge_evt) begin
`ifdef RO_EDGE_CNT_SAT_EN
          if (count_q == {COUNT_W{1'b1}}) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
          end
`else
          count_d = count_inc[COUNT_W-1:0];
          if (count_inc[COUNT_W]) begin
            overflow_d = 1'b1;
          end
`endif
        end
        rem_d = rem_q - {{(WIN_W-1){1'b0}}, 1'b1};
        if (rem_q == {{(WIN_W-1){1'b0}}, 1'b1}) begin
          state_d = StHold;
          valid_d = 1'b1;
        end
      end
      StHold: begin
        if (ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= StIdle;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      arm_q      <= 1'b0;
      win_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= osc_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      arm_q      <= arm_d;
      win_q      <= win_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_edge_counter.sv
// Directed bench for ro_edge_counter: a 16-bit instance plus a 4-bit instance for overflow.
`timescale 1ns/1ps

module tb_ro_edge_counter;

  logic        CLK = 1'b0;
  logic        RN = 1'b0;
  logic        osc_in = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [11:0] win_len = '0;
  logic        busy, valid, overflow;
  logic [15:0] count;
  logic        busy4, valid4, overflow4;
  logic [3:0]  count4;

  int errors = 0;
  int checks = 0;
  int osc_period = 2;
  int osc_ph = 0;
  logic osc_static = 1'b0;
  logic [15:0] saved;

  ro_edge_counter #(.COUNT_W(16), .WIN_W(12)) dut (
    .CLK(CLK), .RN(RN), .osc_in(osc_in), .start(start), .win_len(win_len),
    .busy(busy), .valid(valid), .ready(ready), .count(count), .overflow(overflow)
  );

  ro_edge_counter #(.COUNT_W(4), .WIN_W(12)) dut4 (
    .CLK(CLK), .RN(RN), .osc_in(osc_in), .start(start), .win_len(win_len),
    .busy(busy4), .valid(valid4), .ready(ready), .count(count4), .overflow(overflow4)
  );

  always #5 CLK = ~CLK;

  // Oscillator model: toggles on falling CLK every osc_period/2 cycles; 0 = static level.
  initial begin
    forever begin
      @(negedge CLK);
      if (osc_period == 0) begin
        osc_in = osc_static;
        osc_ph = 0;
      end else begin
        osc_ph++;
        if (osc_ph >= osc_period / 2) begin
          osc_in = ~osc_in;
          osc_ph = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Returns in the cycle after acceptance (N+1).
  task automatic do_start(input logic [11:0] w);
    @(negedge CLK);
    win_len = w;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic handshake(input string name);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake: valid=%b busy=%b want 0 0", name, valid, busy);
    end
  endtask

  task automatic test_reset;
    RN = 1'b0;
    osc_period = 2;
    step(5);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b count=%0d ovf=%b want 0 0 0 0",
               busy, valid, count, overflow);
    end
    checks++;
    if (busy4 !== 1'b0 || valid4 !== 1'b0 || count4 !== 4'd0 || overflow4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs4: busy=%b valid=%b count=%0d ovf=%b want 0 0 0 0",
               busy4, valid4, count4, overflow4);
    end
    @(negedge CLK);
    RN = 1'b1;
    ready = 1'b1;
    step(8);
    ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || count !== 16'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b valid=%b count=%0d want 0 0 0", busy, valid, count);
    end
  endtask

  task automatic test_basic;
    osc_period = 8;
    step(3);
    do_start(12'd64);
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b valid=%b want 1 0", busy, valid);
    end
    step(65);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: valid=%b want 0", valid);
    end
    step(1);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid: valid=%b want 1", valid);
    end
    checks++;
    if ($isunknown(count) || count < 16'd7 || count > 16'd9 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_count: count=%0d ovf=%b want 7..9 0", count, overflow);
    end
    saved = count;
    step(10);
    checks++;
    if (valid !== 1'b1 || count !== saved) begin
      errors++;
      $display("FAIL basic_hold: valid=%b count=%0d want 1 %0d", valid, count, saved);
    end
    handshake("basic");
  endtask

  task automatic test_zero_window;
    do_start(12'd0);
    step(1);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_arm: valid=%b busy=%b want 0 1", valid, busy);
    end
    step(1);
    checks++;
    if (valid !== 1'b1 || count !== 16'd0) begin
      errors++;
      $display("FAIL zero_result: valid=%b count=%0d want 1 0", valid, count);
    end
    start = 1'b1;
    win_len = 12'd5;
    step(2);
    checks++;
    if (valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_start_in_hold: valid=%b busy=%b want 1 1", valid, busy);
    end
    ready = 1'b1;
    step(1);
    start = 1'b0;
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_handshake: valid=%b busy=%b want 0 0", valid, busy);
    end
    step(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_start_ignored: busy=%b want 0", busy);
    end
  endtask

  task automatic test_overflow;
    osc_period = 4;
    step(4);
    do_start(12'd100);
    step(102);
    checks++;
    if (valid4 !== 1'b1 || overflow4 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: valid=%b ovf=%b want 1 1", valid4, overflow4);
    end
`ifdef RO_EDGE_CNT_SAT_EN
    checks++;
    if (count4 !== 4'd15) begin
      errors++;
      $display("FAIL ovf_sat_count: count=%0d want 15", count4);
    end
`else
    checks++;
    if ($isunknown(count4) || count4 < 4'd8 || count4 > 4'd10) begin
      errors++;
      $display("FAIL ovf_wrap_count: count=%0d want 8..10", count4);
    end
`endif
    checks++;
    if ($isunknown(count) || count < 16'd24 || count > 16'd26 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wide_count: count=%0d ovf=%b want 24..26 0", count, overflow);
    end
    handshake("ovf");
    do_start(12'd0);
    step(2);
    checks++;
    if (overflow4 !== 1'b0 || count4 !== 4'd0) begin
      errors++;
      $display("FAIL ovf_cleared: ovf=%b count=%0d want 0 0", overflow4, count4);
    end
    handshake("ovf_clear");
  endtask

  task automatic test_reset_mid;
    osc_period = 8;
    do_start(12'd64);
    step(21);
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_running: busy=%b valid=%b want 1 0", busy, valid);
    end
    #2;
    RN = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b count=%0d ovf=%b want 0 0 0 0",
               busy, valid, count, overflow);
    end
    @(negedge CLK);
    RN = 1'b1;
    step(2);
    do_start(12'd64);
    step(65);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rerun_early: valid=%b want 0", valid);
    end
    step(1);
    checks++;
    if (valid !== 1'b1 || $isunknown(count) || count < 16'd7 || count > 16'd9) begin
      errors++;
      $display("FAIL mid_rerun: valid=%b count=%0d want 1 7..9", valid, count);
    end
    handshake("mid");
  endtask

  task automatic test_static;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      osc_period = 0;
      osc_static = lvl[0];
      step(5);
      do_start(12'd50);
      step(51);
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL static%0d_early: valid=%b want 0", lvl, valid);
      end
      step(1);
      checks++;
      if (valid !== 1'b1 || count !== 16'd0) begin
        errors++;
        $display("FAIL static%0d_result: valid=%b count=%0d want 1 0", lvl, valid, count);
      end
      handshake("static");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_window;
    test_overflow;
    test_reset_mid;
    test_static;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
